// File: rtl/nco_clock_enable_gen.sv
// Multi-channel phase-accumulator clock-enable generator: each channel emits a
// strobe on accumulator carry, a square wave from the accumulator MSB and a lock flag.
module nco_clock_enable_gen #(
    parameter int               N_CH        = 4,
    parameter int               ACC_W       = 32,
    parameter int               LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0] INIT_INC    = ACC_W'(32'h0100_0000)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]                      cfg_inc,
    input  logic                                  cfg_phase_reset,
    output logic [N_CH-1:0]                       strobe,
    output logic [N_CH-1:0]                       square,
    output logic [N_CH-1:0]                       lock
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } cfg_state_t;

    cfg_state_t       state_reg;
    logic             cfg_ready_reg;
    logic [CH_W-1:0]  pend_ch_reg;
    logic [ACC_W-1:0] pend_inc_reg;
    logic             pend_phase_reset_reg;
    logic             apply_en;

    // Request is latched in IDLE and committed on the single APPLY cycle that follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= S_IDLE;
            cfg_ready_reg        <= 1'b0;
            pend_ch_reg          <= '0;
            pend_inc_reg         <= '0;
            pend_phase_reset_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    cfg_ready_reg <= 1'b1;
                    if (cfg_valid && cfg_ready_reg) begin
                        state_reg            <= S_APPLY;
                        cfg_ready_reg        <= 1'b0;
                        pend_ch_reg          <= cfg_ch;
                        pend_inc_reg         <= cfg_inc;
                        pend_phase_reset_reg <= cfg_phase_reset;
                    end
                end
                S_APPLY: begin
                    state_reg     <= S_IDLE;
                    cfg_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= S_IDLE;
                    cfg_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_reg;
    assign apply_en  = (state_reg == S_APPLY);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [ACC_W-1:0] acc_reg;
            logic [ACC_W-1:0] inc_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             strobe_reg;
            logic             lock_reg;
            logic [ACC_W:0]   sum;
            logic             hit;

            assign sum = {1'b0, acc_reg} + {1'b0, inc_reg};
            // An out-of-range pending index never matches, so it touches no channel.
            assign hit = apply_en && (pend_ch_reg == CH_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg    <= '0;
                    inc_reg    <= INIT_INC;
                    cnt_reg    <= '0;
                    strobe_reg <= 1'b0;
                    lock_reg   <= 1'b0;
                end else if (hit) begin
                    inc_reg  <= pend_inc_reg;
                    cnt_reg  <= '0;
                    lock_reg <= 1'b0;
                    if (pend_phase_reset_reg) begin
                        acc_reg    <= '0;
                        strobe_reg <= 1'b0;
                    end else begin
                        acc_reg    <= sum[ACC_W-1:0];
                        strobe_reg <= sum[ACC_W];
                    end
                end else begin
                    acc_reg    <= sum[ACC_W-1:0];
                    strobe_reg <= sum[ACC_W];
                    if (sum[ACC_W] && (cnt_reg != LOCK_MAX))
                        cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LOCK_MAX)
                        lock_reg <= 1'b1;
                end
            end

            assign strobe[gi] = strobe_reg;
            assign square[gi] = acc_reg[ACC_W-1];
            assign lock[gi]   = lock_reg;
        end
    endgenerate

endmodule

// File: tb/tb_nco_clock_enable_gen.sv
// Directed bench for nco_clock_enable_gen (2 channels, 8-bit accumulator, lock after 3
// strobes); a 3-channel instance exercises an out-of-range channel index.
module tb_nco_clock_enable_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_ch;
    logic [7:0] cfg_inc;
    logic       cfg_phase_reset;
    logic [1:0] strobe;
    logic [1:0] square;
    logic [1:0] lock;

    logic       cfg_valid3;
    logic       cfg_ready3;
    logic [1:0] cfg_ch3;
    logic [2:0] strobe3;
    logic [2:0] square3;
    logic [2:0] lock3;

    int tests = 0;
    int fails = 0;
    int k     = 0;

    always #5 clk = ~clk;

    nco_clock_enable_gen #(
        .N_CH(2), .ACC_W(8), .LOCK_CYCLES(3), .INIT_INC(8'h40)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc), .cfg_phase_reset(cfg_phase_reset),
        .strobe(strobe), .square(square), .lock(lock)
    );

    nco_clock_enable_gen #(
        .N_CH(3), .ACC_W(8), .LOCK_CYCLES(3), .INIT_INC(8'h40)
    ) u_dut3 (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3),
        .cfg_inc(cfg_inc), .cfg_phase_reset(cfg_phase_reset),
        .strobe(strobe3), .square(square3), .lock(lock3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Expected pattern with the reset increment 0x40: acc = 0x40*k mod 256.
    function automatic logic init_strb(input int kk);
        return (kk > 0) && (kk % 4 == 0);
    endfunction

    function automatic logic init_sq(input int kk);
        return (kk % 4 == 2) || (kk % 4 == 3);
    endfunction

    task automatic check_init_window();
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("init_strobe", 32'(strobe), 32'({2{init_strb(k)}}));
            chk("init_square", 32'(square), 32'({2{init_sq(k)}}));
            chk("init_lock",   32'(lock),   32'({2{k >= 13}}));
            chk("init_ready",  32'(cfg_ready), 32'(1'b1));
        end
    endtask

    task automatic request(input logic ch, input logic [7:0] inc, input logic pr);
        cfg_valid       = 1'b1;
        cfg_ch          = ch;
        cfg_inc         = inc;
        cfg_phase_reset = pr;
    endtask

    int n_strb0, n_lock0, n_sq0, n_ch1, n_max;

    initial begin
        rst             = 1'b1;
        cfg_valid       = 1'b0;
        cfg_ch          = 1'b0;
        cfg_inc         = 8'h00;
        cfg_phase_reset = 1'b0;
        cfg_valid3      = 1'b0;
        cfg_ch3         = 2'd0;

        // Reset state
        tick();
        tick();
        chk("rst_ready",  32'(cfg_ready), 32'(1'b0));
        chk("rst_strobe", 32'(strobe),    32'(2'b00));
        chk("rst_square", 32'(square),    32'(2'b00));
        chk("rst_lock",   32'(lock),      32'(2'b00));
        chk("rst_ready3", 32'(cfg_ready3), 32'(1'b0));
        rst = 1'b0;
        k   = 0;
        check_init_window();

        // Retune channel 1 to 0x80 without phase reset
        request(1'b1, 8'h80, 1'b0);
        tick();
        chk("rt_ready_lo", 32'(cfg_ready), 32'(1'b0));
        chk("rt_lock_pre", 32'(lock),      32'(2'b11));
        cfg_valid = 1'b0;
        tick();
        chk("rt_ready_hi", 32'(cfg_ready), 32'(1'b1));
        chk("rt_lock_drop", 32'(lock),     32'(2'b01));
        chk("rt_strobe_apply", 32'(strobe), 32'(2'b11));
        chk("rt_square_apply", 32'(square), 32'(2'b00));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rt_strobe", 32'(strobe), 32'({(k % 2 == 0), (k % 4 == 0)}));
            chk("rt_square", 32'(square), 32'({(k % 2 == 1), init_sq(k)}));
            chk("rt_lock",   32'(lock),   32'({(k >= 23), 1'b1}));
        end

        // Phase reset of channel 0 at the edge where acc[0] would wrap from 0xC0
        request(1'b0, 8'h40, 1'b1);
        tick();
        chk("pr_ready_lo", 32'(cfg_ready), 32'(1'b0));
        cfg_valid = 1'b0;
        tick();
        chk("pr_strobe_apply", 32'(strobe), 32'(2'b10));
        chk("pr_lock_apply",   32'(lock),   32'(2'b10));
        chk("pr_square_apply", 32'(square[0]), 32'(1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pr_strobe0", 32'(strobe[0]), 32'(k == 32));
            chk("pr_square0", 32'(square[0]), 32'(init_sq(k)));
            chk("pr_lock0",   32'(lock[0]),   32'(1'b0));
        end

        // Freeze channel 0 with a zero increment
        request(1'b0, 8'h00, 1'b0);
        tick();
        chk("fz_ready_lo", 32'(cfg_ready), 32'(1'b0));
        cfg_valid = 1'b0;
        tick();
        chk("fz_strobe_apply", 32'(strobe[0]), 32'(1'b0));
        chk("fz_square_apply", 32'(square[0]), 32'(1'b1));
        n_strb0 = 0; n_lock0 = 0; n_sq0 = 0; n_ch1 = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (strobe[0] !== 1'b0) n_strb0++;
            if (lock[0] !== 1'b0) n_lock0++;
            if (square[0] !== 1'b1) n_sq0++;
            if (strobe[1] !== (k % 2 == 0)) n_ch1++;
        end
        chk("fz_strobe0_count", 32'(n_strb0), 32'(0));
        chk("fz_lock0_count",   32'(n_lock0), 32'(0));
        chk("fz_square0_held",  32'(n_sq0),   32'(0));
        chk("fz_ch1_undisturbed", 32'(n_ch1), 32'(0));
        chk("fz_lock1", 32'(lock[1]), 32'(1'b1));

        // Out-of-range channel index on the 3-channel instance
        cfg_valid3      = 1'b1;
        cfg_ch3         = 2'd3;
        cfg_inc         = 8'h00;
        cfg_phase_reset = 1'b1;
        tick();
        chk("inv_ready_lo", 32'(cfg_ready3), 32'(1'b0));
        cfg_valid3 = 1'b0;
        tick();
        chk("inv_ready_hi", 32'(cfg_ready3), 32'(1'b1));
        chk("inv_strobe",   32'(strobe3),    32'(3'b111));
        chk("inv_lock",     32'(lock3),      32'(3'b111));
        tick();
        chk("inv_strobe_off", 32'(strobe3), 32'(3'b000));
        chk("inv_square_lo",  32'(square3), 32'(3'b000));
        tick();
        chk("inv_square_hi",  32'(square3), 32'(3'b111));
        chk("inv_lock_held",  32'(lock3),   32'(3'b111));

        // Back-to-back requests with cfg_valid held high
        request(1'b1, 8'h80, 1'b0);
        tick();
        chk("b2b_ready_t",   32'(cfg_ready), 32'(1'b0));
        request(1'b0, 8'h40, 1'b0);
        tick();
        chk("b2b_ready_t1",  32'(cfg_ready), 32'(1'b1));
        chk("b2b_lock1_drop", 32'(lock[1]),  32'(1'b0));
        tick();
        chk("b2b_ready_t2",  32'(cfg_ready), 32'(1'b0));
        cfg_valid = 1'b0;
        tick();
        chk("b2b_ready_t3",  32'(cfg_ready), 32'(1'b1));
        chk("b2b_strobe1",   32'(strobe[1]), 32'(1'b1));
        tick();
        chk("b2b_ready_t4",  32'(cfg_ready), 32'(1'b1));
        chk("b2b_strobe0_lo", 32'(strobe[0]), 32'(1'b0));
        tick();
        chk("b2b_strobe0_hi", 32'(strobe[0]), 32'(1'b1));

        // Reset asserted during APPLY discards the request
        request(1'b0, 8'hFF, 1'b0);
        tick();
        chk("mr_ready_lo", 32'(cfg_ready), 32'(1'b0));
        rst       = 1'b1;
        cfg_valid = 1'b0;
        tick();
        chk("mr_ready",  32'(cfg_ready), 32'(1'b0));
        chk("mr_strobe", 32'(strobe),    32'(2'b00));
        chk("mr_lock",   32'(lock),      32'(2'b00));
        chk("mr_square", 32'(square),    32'(2'b00));
        rst = 1'b0;
        k   = 0;
        check_init_window();
        tick();

        // Maximum increment on channel 0
        request(1'b0, 8'hFF, 1'b0);
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("max_strobe_apply", 32'(strobe[0]), 32'(1'b0));
        chk("max_lock_apply",   32'(lock[0]),   32'(1'b0));
        n_max = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (strobe[0] === 1'b1) n_max++;
            if (k == 20) chk("max_lock_pre",  32'(lock[0]), 32'(1'b0));
            if (k == 21) chk("max_lock_post", 32'(lock[0]), 32'(1'b1));
        end
        chk("max_strobe_count", 32'(n_max),   32'(255));
        chk("max_lock1",        32'(lock[1]), 32'(1'b1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
